// File: rtl/vidmem_loader.sv
// vidmem_loader: Wishbone register block plus page copy engine.
// The sequencer programs a source page and a page count, then starts a
// copy; the engine streams 256-byte pages from the source read port into
// the frame RAM write port one byte at a time.
module vidmem_loader #(
   parameter int ADDRESS_WIDTH  = 16,
   parameter int DATA_WIDTH     = 8,
   parameter int DATA_BYTES     = 1,
   parameter int RAM_ADDR_WIDTH = 15,
   parameter int SRC_TIMEOUT    = 64
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [ADDRESS_WIDTH-1:0]  adr_i,
   input  logic [DATA_WIDTH-1:0]     dat_i,
   output logic [DATA_WIDTH-1:0]     dat_o,
   input  logic                      we_i,
   input  logic [DATA_BYTES-1:0]     sel_i,
   input  logic                      stb_i,
   input  logic                      cyc_i,
   output logic                      ack_o,
   input  logic [2:0]                cti_i,
   output logic [23:0]               src_addr,
   output logic                      src_req,
   input  logic                      src_valid,
   input  logic [7:0]                src_data,
   output logic                      ram_we,
   output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
   output logic [7:0]                ram_data,
   output logic                      mem_busy
);

   localparam int TIMER_WIDTH = (SRC_TIMEOUT > 1) ? $clog2(SRC_TIMEOUT) : 1;
   localparam logic [TIMER_WIDTH-1:0] TIMER_MAX = TIMER_WIDTH'(SRC_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_WRITE
   } state_t;

   state_t                    state;
   logic [15:0]               page_reg;
   logic [15:0]               count_reg;
   logic [15:0]               cur_page;
   logic [15:0]               remaining;
   logic [7:0]                offset;
   logic [RAM_ADDR_WIDTH-1:0] dest;
   logic [TIMER_WIDTH-1:0]    timer;
   logic [7:0]                byte_buf;
   logic                      done;
   logic                      error;

   logic                      wb_req;
   logic                      wr_en;
   logic [2:0]                reg_sel;
   logic                      start;
   logic [7:0]                wr_byte;
   logic [7:0]                rd_data;
   logic                      unused_bits;

   // An access is accepted once per beat: the cycle carrying ack_o never
   // counts as a new request, so a held strobe costs two cycles per beat.
   assign wb_req  = stb_i & cyc_i & ~ack_o;
   assign wr_en   = wb_req & we_i & sel_i[0];
   assign reg_sel = adr_i[2:0];
   assign wr_byte = dat_i[7:0];
   assign start   = wr_en & (reg_sel == 3'd0) & wr_byte[0];

   assign unused_bits = ^{adr_i, cti_i, sel_i, dat_i};

   // The engine reads its address and write port straight from its own
   // registers, so these outputs carry no combinational logic.
   assign src_addr = {cur_page, offset};
   assign ram_addr = dest;
   assign ram_data = byte_buf;

   // Register read multiplexer; unmapped offsets read as zero.
   always_comb begin
      rd_data = 8'h00;
      case (reg_sel)
         3'd0:    rd_data = {5'b00000, error, done, mem_busy};
         3'd4:    rd_data = page_reg[7:0];
         3'd5:    rd_data = page_reg[15:8];
         3'd6:    rd_data = count_reg[7:0];
         3'd7:    rd_data = count_reg[15:8];
         default: rd_data = 8'h00;
      endcase
   end

   // Wishbone slave: registered ack and read data, register writes commit
   // on the same edge that raises ack_o.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ack_o     <= 1'b0;
         dat_o     <= '0;
         page_reg  <= 16'h0000;
         count_reg <= 16'h0000;
      end else begin
         ack_o <= wb_req;
         dat_o <= wb_req ? DATA_WIDTH'(rd_data) : '0;
         if (wr_en) begin
            case (reg_sel)
               3'd4:    page_reg[7:0]   <= wr_byte;
               3'd5:    page_reg[15:8]  <= wr_byte;
               3'd6:    count_reg[7:0]  <= wr_byte;
               3'd7:    count_reg[15:8] <= wr_byte;
               default: ;
            endcase
         end
      end
   end

   // Copy engine: outputs are set on the transition into the state that
   // owns them, so src_req is high during REQ and ram_we during WRITE.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state     <= ST_IDLE;
         cur_page  <= 16'h0000;
         remaining <= 16'h0000;
         offset    <= 8'h00;
         dest      <= '0;
         timer     <= '0;
         byte_buf  <= 8'h00;
         src_req   <= 1'b0;
         ram_we    <= 1'b0;
         mem_busy  <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         if (start) begin
            done  <= 1'b0;
            error <= 1'b0;
         end
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (count_reg != 16'h0000) begin
                     cur_page  <= page_reg;
                     remaining <= count_reg;
                     offset    <= 8'h00;
                     dest      <= '0;
                     src_req   <= 1'b1;
                     mem_busy  <= 1'b1;
                     state     <= ST_REQ;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            ST_REQ: begin
               src_req <= 1'b0;
               timer   <= '0;
               state   <= ST_WAIT;
            end
            ST_WAIT: begin
               if (src_valid) begin
                  byte_buf <= src_data;
                  ram_we   <= 1'b1;
                  state    <= ST_WRITE;
               end else if (timer == TIMER_MAX) begin
                  error    <= 1'b1;
                  mem_busy <= 1'b0;
                  state    <= ST_IDLE;
               end else begin
                  timer <= timer + TIMER_WIDTH'(1);
               end
            end
            ST_WRITE: begin
               ram_we <= 1'b0;
               dest   <= dest + RAM_ADDR_WIDTH'(1);
               offset <= offset + 8'd1;
               if (offset == 8'hFF) begin
                  cur_page  <= cur_page + 16'd1;
                  remaining <= remaining - 16'd1;
                  if (remaining == 16'd1) begin
                     done     <= 1'b1;
                     mem_busy <= 1'b0;
                     state    <= ST_IDLE;
                  end else begin
                     src_req <= 1'b1;
                     state   <= ST_REQ;
                  end
               end else begin
                  src_req <= 1'b1;
                  state   <= ST_REQ;
               end
            end
            default: begin
               src_req  <= 1'b0;
               ram_we   <= 1'b0;
               mem_busy <= 1'b0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vidmem_loader.sv
// tb_vidmem_loader: scoreboard bench for the frame-memory loader.
// A source model answers each src_req one cycle later and pushes the frame
// RAM write it expects; a monitor pops and compares on every ram_we.
module tb_vidmem_loader;

   logic        clk_i;
   logic        rst_i;
   logic [15:0] adr_i;
   logic [7:0]  dat_i;
   logic [7:0]  dat_o;
   logic        we_i;
   logic [0:0]  sel_i;
   logic        stb_i;
   logic        cyc_i;
   logic        ack_o;
   logic [2:0]  cti_i;
   logic [23:0] src_addr;
   logic        src_req;
   logic        src_valid;
   logic [7:0]  src_data;
   logic        ram_we;
   logic [14:0] ram_addr;
   logic [7:0]  ram_data;
   logic        mem_busy;

   int checkCount = 0;
   int passCount  = 0;
   int ramWrites  = 0;
   int cycleCount = 0;
   int lastReqCycle = 0;

   logic        srcEnable = 1'b0;
   logic [15:0] expPage   = 16'h0000;
   logic [7:0]  expOffset = 8'h00;
   logic [14:0] expDest   = 15'h0000;
   logic [22:0] ramQueue[$];

   vidmem_loader dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .adr_i     (adr_i),
      .dat_i     (dat_i),
      .dat_o     (dat_o),
      .we_i      (we_i),
      .sel_i     (sel_i),
      .stb_i     (stb_i),
      .cyc_i     (cyc_i),
      .ack_o     (ack_o),
      .cti_i     (cti_i),
      .src_addr  (src_addr),
      .src_req   (src_req),
      .src_valid (src_valid),
      .src_data  (src_data),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_data  (ram_data),
      .mem_busy  (mem_busy)
   );

   // 10-unit clock period
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // Free-running cycle count used to time the source timeout
   always @(posedge clk_i) cycleCount <= cycleCount + 1;

   // Single point of comparison: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
   endtask

   // Source memory contents as a function of the 24-bit byte address
   function automatic logic [7:0] srcByte(input logic [23:0] a);
      return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
   endfunction

   // Reset the copy model before a start command
   task automatic startModel(input logic [15:0] page);
      expPage   = page;
      expOffset = 8'h00;
      expDest   = 15'h0000;
      ramQueue.delete();
   endtask

   // Source model: check the requested address, answer one cycle later and
   // push the frame RAM write that must follow
   initial begin
      logic [23:0] a;
      logic [7:0]  d;
      src_valid = 1'b0;
      src_data  = 8'h00;
      forever begin
         @(negedge clk_i);
         if (src_req === 1'b1) begin
            lastReqCycle = cycleCount;
            if (srcEnable) begin
               a = {expPage, expOffset};
               checkOutput("src_addr", 32'(src_addr), 32'(a));
               d = srcByte(a);
               @(posedge clk_i);
               #1;
               src_valid = 1'b1;
               src_data  = d;
               ramQueue.push_back({expDest, d});
               expDest   = expDest + 15'd1;
               expOffset = expOffset + 8'd1;
               if (expOffset == 8'h00) expPage = expPage + 16'd1;
               @(posedge clk_i);
               #1;
               src_valid = 1'b0;
            end
         end
      end
   end

   // Frame RAM monitor: pop and compare each write
   initial begin
      logic [22:0] e;
      forever begin
         @(negedge clk_i);
         if (ram_we === 1'b1) begin
            ramWrites++;
            if (ramQueue.size() == 0) begin
               checkOutput("ram_we_unexpected", 32'(1), 32'(0));
            end else begin
               e = ramQueue.pop_front();
               checkOutput("ram_addr", 32'(ram_addr), 32'(e[22:8]));
               checkOutput("ram_data", 32'(ram_data), 32'(e[7:0]));
            end
         end
      end
   end

   // Hard stop in case something hangs outside the bounded waits
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // One Wishbone beat; call #1 after a clock edge, returns #1 after the ack edge
   task automatic applyStimulus(input logic [2:0] a, input logic w, input logic [7:0] d,
                                output logic [7:0] r, output int lat);
      adr_i = {13'b0, a};
      we_i  = w;
      dat_i = d;
      sel_i = 1'b1;
      stb_i = 1'b1;
      cyc_i = 1'b1;
      lat   = 0;
      do begin
         @(posedge clk_i);
         #1;
         lat++;
      end while (!ack_o && lat < 8);
      r = dat_o;
   endtask

   // Close the cycle and leave one idle clock
   task automatic wbEnd();
      stb_i = 1'b0;
      cyc_i = 1'b0;
      we_i  = 1'b0;
      cti_i = 3'b000;
      @(posedge clk_i);
      #1;
   endtask

   task automatic wbWrite(input logic [2:0] a, input logic [7:0] d);
      logic [7:0] r;
      int lat;
      applyStimulus(a, 1'b1, d, r, lat);
      wbEnd();
   endtask

   task automatic wbRead(input logic [2:0] a, output logic [7:0] r);
      int lat;
      applyStimulus(a, 1'b0, 8'h00, r, lat);
      wbEnd();
   endtask

   task automatic setPageCount(input logic [15:0] page, input logic [15:0] count);
      wbWrite(3'd4, page[7:0]);
      wbWrite(3'd5, page[15:8]);
      wbWrite(3'd6, count[7:0]);
      wbWrite(3'd7, count[15:8]);
   endtask

   // Bounded wait for the engine to go idle
   task automatic waitIdle(input int maxCycles, input string tag);
      int n;
      n = 0;
      while (mem_busy && n < maxCycles) begin
         @(posedge clk_i);
         #1;
         n++;
      end
      checkOutput(tag, 32'(mem_busy), 32'(0));
   endtask

   // Main sequence
   initial begin
      logic [7:0] r;
      int lat;
      int base;
      int n;

      rst_i  = 1'b0;
      adr_i  = 16'h0000;
      dat_i  = 8'h00;
      we_i   = 1'b0;
      sel_i  = 1'b0;
      stb_i  = 1'b0;
      cyc_i  = 1'b0;
      cti_i  = 3'b000;

      // Reset state
      repeat (3) @(posedge clk_i);
      #1;
      checkOutput("rst_ack", 32'(ack_o), 32'(0));
      checkOutput("rst_dat", 32'(dat_o), 32'(0));
      checkOutput("rst_src_req", 32'(src_req), 32'(0));
      checkOutput("rst_ram_we", 32'(ram_we), 32'(0));
      checkOutput("rst_busy", 32'(mem_busy), 32'(0));
      checkOutput("rst_src_addr", 32'(src_addr), 32'(0));
      checkOutput("rst_ram_addr", 32'(ram_addr), 32'(0));
      checkOutput("rst_ram_data", 32'(ram_data), 32'(0));
      @(negedge clk_i);
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      wbRead(3'd0, r); checkOutput("rst_control", 32'(r), 32'(0));
      wbRead(3'd4, r); checkOutput("rst_page_l", 32'(r), 32'(0));
      wbRead(3'd7, r); checkOutput("rst_count_h", 32'(r), 32'(0));

      // Burst write at offset 4: first beat 1 cycle, later beats 2 cycles
      cti_i = 3'b010;
      applyStimulus(3'd4, 1'b1, 8'h10, r, lat); checkOutput("burst_lat0", 32'(lat), 32'(1));
      applyStimulus(3'd5, 1'b1, 8'h00, r, lat); checkOutput("burst_lat1", 32'(lat), 32'(2));
      applyStimulus(3'd6, 1'b1, 8'h02, r, lat); checkOutput("burst_lat2", 32'(lat), 32'(2));
      cti_i = 3'b111;
      applyStimulus(3'd7, 1'b1, 8'h00, r, lat); checkOutput("burst_lat3", 32'(lat), 32'(2));
      wbEnd();
      checkOutput("ack_single_cycle", 32'(ack_o), 32'(0));
      applyStimulus(3'd4, 1'b0, 8'h00, r, lat); checkOutput("read_lat", 32'(lat), 32'(1));
      checkOutput("page_l", 32'(r), 32'h10);
      wbEnd();
      wbRead(3'd5, r); checkOutput("page_h", 32'(r), 32'h00);
      wbRead(3'd6, r); checkOutput("count_l", 32'(r), 32'h02);
      wbRead(3'd7, r); checkOutput("count_h", 32'(r), 32'h00);
      wbRead(3'd2, r); checkOutput("unmapped_read", 32'(r), 32'h00);

      // Cycle dropped before the ack edge: no ack, no write
      adr_i = 16'd4; dat_i = 8'hAA; we_i = 1'b1; sel_i = 1'b1; stb_i = 1'b1; cyc_i = 1'b1;
      #3;
      stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0;
      @(posedge clk_i);
      #1;
      checkOutput("abort_no_ack", 32'(ack_o), 32'(0));
      wbRead(3'd4, r); checkOutput("abort_no_write", 32'(r), 32'h10);

      // Two-page copy from page 0x0010
      startModel(16'h0010);
      srcEnable = 1'b1;
      base = ramWrites;
      wbWrite(3'd0, 8'h01);
      checkOutput("busy_after_start", 32'(mem_busy), 32'(1));
      waitIdle(3000, "copy2_idle");
      checkOutput("copy2_writes", 32'(ramWrites - base), 32'(512));
      checkOutput("copy2_queue_empty", 32'(ramQueue.size()), 32'(0));
      wbRead(3'd0, r); checkOutput("copy2_control", 32'(r), 32'h02);

      // Zero page count: done without ever going busy
      wbWrite(3'd6, 8'h00);
      wbWrite(3'd7, 8'h00);
      base = ramWrites;
      wbWrite(3'd0, 8'h01);
      n = 0;
      for (int i = 0; i < 6; i++) begin
         if (mem_busy) n++;
         @(posedge clk_i);
         #1;
      end
      checkOutput("zero_count_busy", 32'(n), 32'(0));
      wbRead(3'd0, r); checkOutput("zero_count_control", 32'(r), 32'h02);
      checkOutput("zero_count_writes", 32'(ramWrites - base), 32'(0));

      // Source never answers: one REQ cycle plus SRC_TIMEOUT wait cycles
      srcEnable = 1'b0;
      startModel(16'h0030);
      wbWrite(3'd6, 8'h01);
      base = ramWrites;
      wbWrite(3'd0, 8'h01);
      waitIdle(300, "timeout_idle");
      checkOutput("timeout_cycles", 32'(cycleCount - lastReqCycle), 32'(65));
      wbRead(3'd0, r); checkOutput("timeout_control", 32'(r), 32'h04);
      checkOutput("timeout_writes", 32'(ramWrites - base), 32'(0));

      // Restart and PAGE write while busy leave the running copy alone
      setPageCount(16'h0020, 16'h0001);
      startModel(16'h0020);
      srcEnable = 1'b1;
      base = ramWrites;
      wbWrite(3'd0, 8'h01);
      repeat (100) @(posedge clk_i);
      #1;
      wbWrite(3'd0, 8'h01);
      wbWrite(3'd4, 8'h55);
      wbWrite(3'd5, 8'h00);
      checkOutput("busy_during_restart", 32'(mem_busy), 32'(1));
      waitIdle(1500, "restart_idle");
      checkOutput("restart_writes", 32'(ramWrites - base), 32'(256));
      checkOutput("restart_queue_empty", 32'(ramQueue.size()), 32'(0));
      wbRead(3'd4, r); checkOutput("restart_page_l", 32'(r), 32'h55);
      wbRead(3'd0, r); checkOutput("restart_control", 32'(r), 32'h02);

      // Page wrap 0xFFFF -> 0x0000, then reset in the middle of page two
      setPageCount(16'hFFFF, 16'h0002);
      startModel(16'hFFFF);
      base = ramWrites;
      wbWrite(3'd0, 8'h01);
      n = 0;
      while ((ramWrites - base) < 300 && n < 2000) begin
         @(posedge clk_i);
         #1;
         n++;
      end
      checkOutput("wrap_progress", 32'((ramWrites - base) >= 300), 32'(1));
      @(negedge clk_i);
      #2;
      rst_i = 1'b0;
      #1;
      checkOutput("async_rst_busy", 32'(mem_busy), 32'(0));
      checkOutput("async_rst_ram_we", 32'(ram_we), 32'(0));
      checkOutput("async_rst_ack", 32'(ack_o), 32'(0));
      checkOutput("async_rst_src_req", 32'(src_req), 32'(0));
      base = ramWrites;
      repeat (4) @(posedge clk_i);
      #1;
      checkOutput("rst_no_more_writes", 32'(ramWrites - base), 32'(0));
      srcEnable = 1'b0;
      ramQueue.delete();
      @(negedge clk_i);
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      checkOutput("post_rst_src_addr", 32'(src_addr), 32'(0));
      wbRead(3'd4, r); checkOutput("post_rst_page_l", 32'(r), 32'(0));
      wbRead(3'd0, r); checkOutput("post_rst_control", 32'(r), 32'(0));
      repeat (5) @(posedge clk_i);
      #1;
      checkOutput("post_rst_idle", 32'(ramWrites - base), 32'(0));

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
